fp_wb_arbiter: RTL and testbench

Write-side front end for the floating-point register file.
- Collects results from two producers, the FPU (source A) and the FP load path (source B), each through a valid/ready handshake into its own small FIFO.
- Round-robin arbitrates one write per cycle and drives the register file write port (Reg_Wr / Rd_Wr / Rd_In).
- Holds a 32-bit pending-write scoreboard so issue logic can stall on FP RAW hazards.

---
 rtl/fp_wb_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_fp_wb_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_wb_arbiter.sv
// -----------------------------------------------------------------------------
// fp_wb_arbiter -- write-side front end for the floating-point register file.
//
// Two producers (A = FPU, B = FP load path) each hand results to a small FIFO
// through a valid/ready handshake. A round-robin arbiter selects one FIFO head
// per cycle and drives the register file write port. A 32-entry pending-write
// scoreboard (Busy) is set at issue and cleared when the write is emitted.
//
// Optional build macro: FWB_STALL_CNT_EN
//   Adds the Stall_Cnt output: a saturating 16-bit count of cycles in which a
//   producer was held off (valid while its FIFO was full).
//
// Ports:
//   CLK, rst_n              clock, asynchronous active-low reset
//   Issue_Valid, Issue_Rd   FP instruction with FP destination issued
//   Busy[31:0]              bit i set = write to f[i] pending
//   A_Valid/A_Ready/A_Rd/A_Data   FPU result handshake
//   B_Valid/B_Ready/B_Rd/B_Data   load result handshake
//   Reg_Wr, Rd_Wr, Rd_In    registered register file write port
//   Stall_Cnt[15:0]         (FWB_STALL_CNT_EN only) stalled-cycle counter
// -----------------------------------------------------------------------------

// Circular FIFO of DEPTH entries; ready/nempty decode from registered count only.
module fp_wb_fifo #(
    parameter int unsigned WIDTH = 37,
    parameter int unsigned DEPTH = 2
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             ready,
    output logic             nempty
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointer wrap is the natural binary overflow.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign ready  = (count != CW'(DEPTH));
    assign nempty = (count != '0);
    assign rdata  = mem[rd_ptr];
endmodule

module fp_wb_arbiter #(
    parameter int unsigned FLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic            CLK,
    input  logic            rst_n,
    input  logic            Issue_Valid,
    input  logic [4:0]      Issue_Rd,
    output logic [31:0]     Busy,
    input  logic            A_Valid,
    output logic            A_Ready,
    input  logic [4:0]      A_Rd,
    input  logic [FLEN-1:0] A_Data,
    input  logic            B_Valid,
    output logic            B_Ready,
    input  logic [4:0]      B_Rd,
    input  logic [FLEN-1:0] B_Data,
    output logic            Reg_Wr,
    output logic [4:0]      Rd_Wr,
    output logic [FLEN-1:0] Rd_In
`ifdef FWB_STALL_CNT_EN
    ,
    output logic [15:0]     Stall_Cnt
`endif
);
    localparam int unsigned EW = 5 + FLEN;

    typedef enum logic {
        PREF_A,
        PREF_B
    } pref_t;

    pref_t          pref_q;
    logic           a_push;
    logic           b_push;
    logic           a_nempty;
    logic           b_nempty;
    logic [EW-1:0]  a_head;
    logic [EW-1:0]  b_head;
    logic           grant_a;
    logic           grant_b;
    logic [4:0]     wr_rd;
    logic [FLEN-1:0] wr_data;
    logic [31:0]    busy_d;

    assign a_push = A_Valid && A_Ready;
    assign b_push = B_Valid && B_Ready;

    fp_wb_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .CLK    (CLK),
        .rst_n  (rst_n),
        .push   (a_push),
        .wdata  ({A_Rd, A_Data}),
        .pop    (grant_a),
        .rdata  (a_head),
        .ready  (A_Ready),
        .nempty (a_nempty)
    );

    fp_wb_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .CLK    (CLK),
        .rst_n  (rst_n),
        .push   (b_push),
        .wdata  ({B_Rd, B_Data}),
        .pop    (grant_b),
        .rdata  (b_head),
        .ready  (B_Ready),
        .nempty (b_nempty)
    );

    always_comb begin
        grant_a = a_nempty && (!b_nempty || (pref_q == PREF_A));
        grant_b = b_nempty && !grant_a;
        wr_rd   = grant_a ? a_head[EW-1 -: 5] : b_head[EW-1 -: 5];
        wr_data = grant_a ? a_head[FLEN-1:0] : b_head[FLEN-1:0];

        // Clear before set so an issue to the index being written wins.
        busy_d = Busy;
        if (grant_a || grant_b) begin
            busy_d[wr_rd] = 1'b0;
        end
        if (Issue_Valid) begin
            busy_d[Issue_Rd] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            pref_q <= PREF_A;
            Busy   <= '0;
            Reg_Wr <= 1'b0;
            Rd_Wr  <= '0;
            Rd_In  <= '0;
        end else begin
            // Preference only rotates when both sources actually competed.
            if (a_nempty && b_nempty) begin
                pref_q <= (pref_q == PREF_A) ? PREF_B : PREF_A;
            end
            Busy   <= busy_d;
            Reg_Wr <= grant_a || grant_b;
            if (grant_a || grant_b) begin
                Rd_Wr <= wr_rd;
                Rd_In <= wr_data;
            end
        end
    end

`ifdef FWB_STALL_CNT_EN
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            Stall_Cnt <= '0;
        end else if (((A_Valid && !A_Ready) || (B_Valid && !B_Ready)) &&
                     (Stall_Cnt != '1)) begin
            Stall_Cnt <= Stall_Cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fp_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fp_wb_arbiter -- self-checking bench for fp_wb_arbiter.
// A queue-based reference model tracks both FIFOs, the round-robin preference,
// the scoreboard and (with FWB_STALL_CNT_EN) the stall counter; a compare
// process checks every output on each falling edge out of reset. Directed
// scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fp_wb_arbiter;
    localparam int unsigned FLEN  = 32;
    localparam int unsigned DEPTH = 2;

    logic            CLK = 1'b0;
    logic            rst_n;
    logic            Issue_Valid;
    logic [4:0]      Issue_Rd;
    logic [31:0]     Busy;
    logic            A_Valid;
    logic            A_Ready;
    logic [4:0]      A_Rd;
    logic [FLEN-1:0] A_Data;
    logic            B_Valid;
    logic            B_Ready;
    logic [4:0]      B_Rd;
    logic [FLEN-1:0] B_Data;
    logic            Reg_Wr;
    logic [4:0]      Rd_Wr;
    logic [FLEN-1:0] Rd_In;
`ifdef FWB_STALL_CNT_EN
    logic [15:0]     Stall_Cnt;
`endif

    fp_wb_arbiter #(
        .FLEN  (FLEN),
        .DEPTH (DEPTH)
    ) dut (
        .CLK         (CLK),
        .rst_n       (rst_n),
        .Issue_Valid (Issue_Valid),
        .Issue_Rd    (Issue_Rd),
        .Busy        (Busy),
        .A_Valid     (A_Valid),
        .A_Ready     (A_Ready),
        .A_Rd        (A_Rd),
        .A_Data      (A_Data),
        .B_Valid     (B_Valid),
        .B_Ready     (B_Ready),
        .B_Rd        (B_Rd),
        .B_Data      (B_Data),
        .Reg_Wr      (Reg_Wr),
        .Rd_Wr       (Rd_Wr),
        .Rd_In       (Rd_In)
`ifdef FWB_STALL_CNT_EN
        ,
        .Stall_Cnt   (Stall_Cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]      rd;
        logic [FLEN-1:0] data;
    } ent_t;

    ent_t            qa[$];
    ent_t            qb[$];
    bit              m_pref_a;
    logic [31:0]     m_busy;
    logic            m_wr;
    logic [4:0]      m_rd;
    logic [FLEN-1:0] m_data;
    logic [15:0]     m_stall;
    bit              m_ra, m_rb, m_ga, m_gb;
    ent_t            m_head;

    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            qa.delete();
            qb.delete();
            m_pref_a = 1'b1;
            m_busy   = '0;
            m_wr     = 1'b0;
            m_rd     = '0;
            m_data   = '0;
            m_stall  = '0;
        end else begin
            m_ra = (qa.size() < DEPTH);
            m_rb = (qb.size() < DEPTH);
            if (((A_Valid && !m_ra) || (B_Valid && !m_rb)) && m_stall != 16'hFFFF)
                m_stall = m_stall + 16'd1;
            m_ga = (qa.size() > 0) && ((qb.size() == 0) || m_pref_a);
            m_gb = (qb.size() > 0) && !m_ga;
            if (qa.size() > 0 && qb.size() > 0) m_pref_a = !m_pref_a;
            if (m_ga) m_head = qa.pop_front();
            else if (m_gb) m_head = qb.pop_front();
            if (m_ga || m_gb) begin
                m_wr   = 1'b1;
                m_rd   = m_head.rd;
                m_data = m_head.data;
                m_busy[m_head.rd] = 1'b0;
            end else begin
                m_wr = 1'b0;
            end
            if (Issue_Valid) m_busy[Issue_Rd] = 1'b1;
            if (A_Valid && m_ra) qa.push_back('{A_Rd, A_Data});
            if (B_Valid && m_rb) qb.push_back('{B_Rd, B_Data});
        end
    end

    // ---------------- compare process + write log ----------------
    logic [36:0] dut_log[$];

    always @(negedge CLK) begin
        if (rst_n) begin
            chk("Reg_Wr",  64'(Reg_Wr),  64'(m_wr));
            chk("Rd_Wr",   64'(Rd_Wr),   64'(m_rd));
            chk("Rd_In",   64'(Rd_In),   64'(m_data));
            chk("Busy",    64'(Busy),    64'(m_busy));
            chk("A_Ready", 64'(A_Ready), 64'(qa.size() < DEPTH));
            chk("B_Ready", 64'(B_Ready), 64'(qb.size() < DEPTH));
`ifdef FWB_STALL_CNT_EN
            chk("Stall_Cnt", 64'(Stall_Cnt), 64'(m_stall));
`endif
            if (Reg_Wr === 1'b1) dut_log.push_back({Rd_Wr, Rd_In});
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [4:0]      sa_rd   [16];
    logic [FLEN-1:0] sa_data [16];
    logic [4:0]      sb_rd   [16];
    logic [FLEN-1:0] sb_data [16];

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    // Present na/nb items with a proper handshake; holds an item until accepted.
    task automatic stream(input int na, input int nb, input int max_cyc, output int cyc);
        int  ia;
        int  ib;
        logic ra;
        logic rb;
        ia  = 0;
        ib  = 0;
        cyc = 0;
        while ((ia < na || ib < nb) && cyc < max_cyc) begin
            A_Valid = (ia < na);
            if (ia < na) begin A_Rd = sa_rd[ia]; A_Data = sa_data[ia]; end
            B_Valid = (ib < nb);
            if (ib < nb) begin B_Rd = sb_rd[ib]; B_Data = sb_data[ib]; end
            @(negedge CLK);
            ra = A_Ready;
            rb = B_Ready;
            @(posedge CLK);
            #2;
            if (A_Valid && ra) ia++;
            if (B_Valid && rb) ib++;
            cyc++;
        end
        A_Valid = 1'b0;
        B_Valid = 1'b0;
        chk("stream_done_in_budget", 64'(cyc < max_cyc || (ia >= na && ib >= nb)), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int cyc;

    initial begin
        rst_n = 1'b0;
        Issue_Valid = 1'b0; Issue_Rd = '0;
        A_Valid = 1'b0; A_Rd = '0; A_Data = '0;
        B_Valid = 1'b0; B_Rd = '0; B_Data = '0;
        repeat (2) @(posedge CLK);
        #2 rst_n = 1'b1;

        // Reset state and idle
        repeat (5) step();
        chk("idle_Reg_Wr",  64'(Reg_Wr),  64'd0);
        chk("idle_Busy",    64'(Busy),    64'd0);
        chk("idle_A_Ready", 64'(A_Ready), 64'd1);
        chk("idle_B_Ready", 64'(B_Ready), 64'd1);
        chk("idle_Rd_Wr",   64'(Rd_Wr),   64'd0);
        chk("idle_Rd_In",   64'(Rd_In),   64'd0);

        // Single write latency and scoreboard clear
        Issue_Valid = 1'b1; Issue_Rd = 5'd3;
        step();
        Issue_Valid = 1'b0;
        chk("issue_busy3", 64'(Busy[3]), 64'd1);
        A_Valid = 1'b1; A_Rd = 5'd3; A_Data = 32'h3F80_0000;
        step();                                   // edge N: push
        A_Valid = 1'b0;
        chk("lat_N_Reg_Wr", 64'(Reg_Wr), 64'd0);
        step();                                   // edge N+1: write
        chk("lat_N1_Reg_Wr", 64'(Reg_Wr), 64'd1);
        chk("lat_N1_Rd_Wr",  64'(Rd_Wr),  64'd3);
        chk("lat_N1_Rd_In",  64'(Rd_In),  64'h3F80_0000);
        chk("lat_N1_busy3",  64'(Busy[3]), 64'd0);
        step();                                   // edge N+2
        chk("lat_N2_Reg_Wr", 64'(Reg_Wr), 64'd0);

        // Both sources streaming: strict alternation A1,B11,A2,B12,...
        dut_log.delete();
        for (int i = 0; i < 6; i++) begin
            sa_rd[i] = 5'(i + 1);  sa_data[i] = 32'hA000_0000 + 32'(i);
            sb_rd[i] = 5'(i + 11); sb_data[i] = 32'hB000_0000 + 32'(i);
        end
        stream(6, 6, 40, cyc);
        repeat (4) step();
        chk("rr_write_count", 64'(dut_log.size()), 64'd12);
        for (int i = 0; i < 6; i++) begin
            if (dut_log.size() > 2 * i + 1) begin
                chk("rr_write_A", 64'(dut_log[2 * i]),
                    64'({5'(i + 1), 32'hA000_0000 + 32'(i)}));
                chk("rr_write_B", 64'(dut_log[2 * i + 1]),
                    64'({5'(i + 11), 32'hB000_0000 + 32'(i)}));
            end
        end
`ifdef FWB_STALL_CNT_EN
        chk("rr_stall_cnt", 64'(Stall_Cnt), 64'd7);
`endif

        // B only, held valid: one write per cycle, never back-pressured
        dut_log.delete();
        for (int i = 0; i < 6; i++) begin
            sb_rd[i] = 5'(i + 20); sb_data[i] = 32'hC000_0000 + 32'(i);
        end
        stream(0, 6, 40, cyc);
        chk("bonly_push_cycles", 64'(cyc), 64'd6);
        repeat (3) step();
        chk("bonly_write_count", 64'(dut_log.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (dut_log.size() > i)
                chk("bonly_write", 64'(dut_log[i]),
                    64'({5'(i + 20), 32'hC000_0000 + 32'(i)}));
        end
`ifdef FWB_STALL_CNT_EN
        chk("bonly_stall_cnt", 64'(Stall_Cnt), 64'd7);
`endif

        // Issue to f7 on the same edge B's f7 head is written: set wins
        B_Valid = 1'b1; B_Rd = 5'd7; B_Data = 32'h4049_0FDB;
        step();
        B_Valid = 1'b0;
        Issue_Valid = 1'b1; Issue_Rd = 5'd7;
        step();
        Issue_Valid = 1'b0;
        chk("setwins_Reg_Wr", 64'(Reg_Wr), 64'd1);
        chk("setwins_Rd_Wr",  64'(Rd_Wr),  64'd7);
        chk("setwins_busy7",  64'(Busy[7]), 64'd1);

        // Asynchronous reset while both FIFOs hold data and a write is out
        Issue_Valid = 1'b1; Issue_Rd = 5'd20;
        A_Valid = 1'b1; A_Rd = 5'd9;  A_Data = 32'h1111_1111;
        B_Valid = 1'b1; B_Rd = 5'd10; B_Data = 32'h2222_2222;
        repeat (3) step();
        Issue_Valid = 1'b0;
        chk("prereset_Reg_Wr", 64'(Reg_Wr), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_Reg_Wr",  64'(Reg_Wr),  64'd0);
        chk("async_rst_Busy",    64'(Busy),    64'd0);
        chk("async_rst_A_Ready", 64'(A_Ready), 64'd1);
        chk("async_rst_B_Ready", 64'(B_Ready), 64'd1);
        A_Valid = 1'b0;
        B_Valid = 1'b0;
        @(posedge CLK);
        #2 rst_n = 1'b1;
        dut_log.delete();
        repeat (10) step();
        chk("postrst_no_stale_writes", 64'(dut_log.size()), 64'd0);
`ifdef FWB_STALL_CNT_EN
        chk("postrst_stall_cnt", 64'(Stall_Cnt), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
